sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port (req / addr_ok / data_ok handshake) between the IF-stage instruction requester and the EXE/MEM-stage data requester.
- Sits between the pipeline's inst/data request interfaces and the single external memory bridge.
- One transaction outstanding at a time.
- Fixed priority: data over inst, so a load/store never waits behind a fetch.

Parameters:
ADDR_W, 32, address width of all three interfaces
DATA_W, 32, data width of all three interfaces
STRB_W, DATA_W/8, byte write-strobe width

Ports:
clk  in  1  system clock
resetn  in  1  reset, asynchronous assert, active-low
inst_req  in  1  instruction request valid; held until inst_addr_ok
inst_wr  in  1  instruction write flag (0 in normal use)
inst_size  in  2  0=byte, 1=half, 2=word
inst_wstrb  in  STRB_W  byte strobes
inst_addr  in  ADDR_W  request address
inst_wdata  in  DATA_W  write data
inst_addr_ok  out  1  one-cycle pulse: inst request accepted
inst_data_ok  out  1  one-cycle pulse: inst transaction complete
inst_rdata  out  DATA_W  read data, valid with inst_data_ok
data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  as inst_*  data requester
data_addr_ok, data_data_ok  out  1  as inst_*
data_rdata  out  DATA_W  as inst_rdata
mem_req  out  1  request to memory; held until mem_addr_ok
mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  as above  registered request fields
mem_addr_ok  in  1  memory accepted request
mem_data_ok  in  1  memory completed transaction
mem_rdata  in  DATA_W  memory read data

Behaviour:
- States:
  - IDLE: no transaction.
  - ADDR: mem_req high, waiting for mem_addr_ok.
  - DATA: waiting for mem_data_ok.
- Owner register: 0=inst, 1=data.
- IDLE: if data_req, grant data; else if inst_req, grant inst.
  - On grant, capture the winner's wr/size/wstrb/addr/wdata into mem_* registers, set owner, go to ADDR.
  - Request sampled in cycle n → mem_req=1 in cycle n+1.
- ADDR: mem_req=1; mem_* stable.
  - On mem_addr_ok: pulse owner's *_addr_ok in the same cycle (combinational from mem_addr_ok & state==ADDR & owner); go to DATA.
  - If mem_addr_ok and mem_data_ok arrive together: pulse both owner's addr_ok and data_ok; go to IDLE.
- DATA: mem_req=0.
  - On mem_data_ok: pulse owner's *_data_ok in the same cycle; route mem_rdata to owner's *_rdata; go to IDLE.
  - A new grant is possible in the cycle after return to IDLE. Minimum transaction-to-transaction gap is one idle cycle.
- Non-owner's addr_ok/data_ok are 0 at all times.
- inst_rdata/data_rdata: both are driven from mem_rdata (cheap fan-out); only meaningful with the respective data_ok.
- mem_data_ok outside DATA/ADDR is ignored. mem_addr_ok outside ADDR is ignored.
- A requester dropping req before its addr_ok is illegal; the arbiter has already captured the fields and completes the transaction regardless.
- Writes return data_ok like reads; rdata is don't-care.
- Reset (resetn low, any time including mid-transaction):
  - state=IDLE, owner=0, mem_req=0, all mem_* registers 0, all addr_ok/data_ok=0.
  - An in-flight memory response after reset release is ignored.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both requesters assert in IDLE, grant goes to the one not granted last; a last_owner flop resets to inst, so data wins the first tie.
- Undefined: fixed data-over-inst priority; no last_owner flop.

Decomposition:
- Package sram_arb_pkg:
  - state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2)
  - owner constants (OWN_INST=1'b0, OWN_DATA=1'b1)
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD)
- One sub-module arb_grant_sel: combinational grant pick from inst_req, data_req and last_owner. Its round-robin logic is the part guarded by ARB_ROUND_ROBIN_EN.

Test Plan:
- Only inst_req, inst_addr=0xBFC00000; memory addr_ok after 2 cycles, data_ok 3 cycles later with rdata=0x3C1DBFC0 → one inst_addr_ok pulse, one inst_data_ok with inst_rdata=0x3C1DBFC0; data_* outputs stay 0.
- inst_req and data_req (load, addr 0x80001000) asserted same cycle → data granted first (mem_addr=0x80001000); inst served after data_data_ok. With ARB_ROUND_ROBIN_EN, a second simultaneous pair grants inst first.
- Data write, wstrb=4'b0011, size=1, wdata=0xDEADBEEF → mem_wr=1, mem_wstrb=4'b0011, mem_wdata=0xDEADBEEF stable for every cycle mem_req=1.
- Memory asserts mem_addr_ok and mem_data_ok in the same cycle → owner receives addr_ok and data_ok together; FSM returns to IDLE next cycle.
- resetn pulled low while in DATA → mem_req and all ok outputs 0 asynchronously. A later mem_data_ok produces no *_data_ok pulse; the next inst_req is served normally.
- Back-to-back inst requests, memory with zero-wait addr_ok → mem_req deasserts for exactly one cycle between transactions; no lost or duplicated pulses over 100 transactions.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM-like inst/data arbiter: FSM states, owner ids, size codes.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner pick between the inst and data requesters.
// ARB_ROUND_ROBIN_EN: ties alternate using last_owner; otherwise data always wins.
module arb_grant_sel
    import sram_arb_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
    input  logic last_owner,
    output logic grant_vld,
    output logic grant_owner
);

    assign grant_vld = inst_req | data_req;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_owner = data_req ? OWN_DATA : OWN_INST;
        // On a tie, hand the port to whoever did not hold it last.
        if (inst_req && data_req) begin
            grant_owner = (last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign grant_owner = data_req ? OWN_DATA : OWN_INST;
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the inst and data requesters, one transaction at a time.
// ARB_ROUND_ROBIN_EN selects alternating tie-break instead of fixed data-over-inst priority.
module sram_like_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
)
(
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [STRB_W-1:0] inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [STRB_W-1:0] data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [STRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       owner_q;
    logic       last_owner;
    logic       grant_vld;
    logic       grant_owner;
    logic       grant_take;
    logic       addr_ok_pulse;
    logic       data_ok_pulse;

    arb_grant_sel u_grant_sel (
        .inst_req    (inst_req),
        .data_req    (data_req),
        .last_owner  (last_owner),
        .grant_vld   (grant_vld),
        .grant_owner (grant_owner)
    );

    assign grant_take = (state_q == IDLE) && grant_vld;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_owner_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_owner_q <= OWN_INST;
        end else if (grant_take) begin
            last_owner_q <= grant_owner;
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_INST;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (grant_vld) state_d = ADDR;
            ADDR: begin
                if (mem_addr_ok) state_d = mem_data_ok ? IDLE : DATA;
            end
            DATA: if (mem_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are latched once at grant and held for the whole transaction.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            owner_q   <= OWN_INST;
            mem_wr    <= 1'b0;
            mem_size  <= '0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (grant_take) begin
                owner_q <= grant_owner;
                if (grant_owner == OWN_DATA) begin
                    mem_wr    <= data_wr;
                    mem_size  <= data_size;
                    mem_wstrb <= data_wstrb;
                    mem_addr  <= data_addr;
                    mem_wdata <= data_wdata;
                end else begin
                    mem_wr    <= inst_wr;
                    mem_size  <= inst_size;
                    mem_wstrb <= inst_wstrb;
                    mem_addr  <= inst_addr;
                    mem_wdata <= inst_wdata;
                end
            end
        end
    end

    assign mem_req = (state_q == ADDR);

    // Handshake pulses pass straight through from memory, gated by state so stray responses vanish.
    assign addr_ok_pulse = (state_q == ADDR) && mem_addr_ok;
    assign data_ok_pulse = ((state_q == DATA) && mem_data_ok) ||
                           ((state_q == ADDR) && mem_addr_ok && mem_data_ok);

    assign inst_addr_ok = addr_ok_pulse && (owner_q == OWN_INST);
    assign inst_data_ok = data_ok_pulse && (owner_q == OWN_INST);
    assign data_addr_ok = addr_ok_pulse && (owner_q == OWN_DATA);
    assign data_data_ok = data_ok_pulse && (owner_q == OWN_DATA);

    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: single fetch, priority, write capture, combined ok, reset, back-to-back.
module tb_sram_like_arbiter;
    import sram_arb_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [3:0]  oks;

    int checks = 0;
    int failures = 0;

    assign oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};

    sram_like_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_all();
        inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_wstrb = 4'hf;
        inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = SZ_WORD; data_wstrb = 4'hf;
        data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    initial begin
        int  n_tx, n_low, cyc, gap_err, pulse_err, addr_err;
        bit  seen;
        bit  first_inst;

        resetn = 1'b0;
        idle_all();
        step(); step(); #1;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_oks", oks, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wr", mem_wr, 0);
        resetn = 1'b1;

        // single inst fetch, addr_ok after 2 cycles, data_ok 3 cycles later
        step(); inst_req = 1; inst_addr = 32'hBFC00000; #1;
        chk("t1_idle_no_req", mem_req, 0);
        step(); #1;
        chk("t1_mem_req", mem_req, 1);
        chk("t1_mem_addr", mem_addr, 32'hBFC00000);
        step(); #1;
        chk("t1_hold_req", mem_req, 1);
        chk("t1_no_aok", oks, 4'b0000);
        step(); mem_addr_ok = 1; #1;
        chk("t1_inst_aok", oks, 4'b1000);
        step(); mem_addr_ok = 0; inst_req = 0; #1;
        chk("t1_data_wait_req", mem_req, 0);
        chk("t1_data_wait_oks", oks, 4'b0000);
        step();
        step(); mem_data_ok = 1; mem_rdata = 32'h3C1DBFC0; #1;
        chk("t1_inst_dok", oks, 4'b0100);
        chk("t1_inst_rdata", inst_rdata, 32'h3C1DBFC0);
        step(); mem_data_ok = 0; #1;
        chk("t1_idle_req", mem_req, 0);
        chk("t1_idle_oks", oks, 4'b0000);

        // simultaneous inst + data load: data first
        step(); inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_addr = 32'h80001000; data_wr = 0;
        step(); #1;
        chk("t2_mem_addr_data", mem_addr, 32'h80001000);
        chk("t2_mem_wr", mem_wr, 0);
        mem_addr_ok = 1; #1;
        chk("t2_data_aok", oks, 4'b0010);
        step(); data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11112222; #1;
        chk("t2_data_dok", oks, 4'b0001);
        chk("t2_data_rdata", data_rdata, 32'h11112222);
        step(); mem_data_ok = 0; #1;
        chk("t2_gap", mem_req, 0);
        step(); #1;
        chk("t2_mem_addr_inst", mem_addr, 32'hBFC00004);
        mem_addr_ok = 1; mem_data_ok = 1; #1;
        chk("t2_inst_both_ok", oks, 4'b1100);
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0; #1;
        chk("t2_back_idle", mem_req, 0);

        // data write: captured fields held while mem_req is high
        step(); data_req = 1; data_wr = 1; data_size = SZ_HALF; data_wstrb = 4'b0011;
        data_wdata = 32'hDEADBEEF; data_addr = 32'h80002000;
        step(); #1;
        chk("t3_ctl_c1", {mem_req, mem_wr, mem_size, mem_wstrb}, {1'b1, 1'b1, 2'd1, 4'b0011});
        chk("t3_wdata_c1", mem_wdata, 32'hDEADBEEF);
        step(); #1;
        chk("t3_ctl_c2", {mem_req, mem_wr, mem_size, mem_wstrb}, {1'b1, 1'b1, 2'd1, 4'b0011});
        chk("t3_wdata_c2", mem_wdata, 32'hDEADBEEF);
        mem_addr_ok = 1; #1;
        chk("t3_data_aok", oks, 4'b0010);
        chk("t3_addr", mem_addr, 32'h80002000);
        step(); data_req = 0; data_wr = 0; data_wdata = 0; data_wstrb = 0; mem_addr_ok = 0; #1;
        chk("t3_req_low", mem_req, 0);
        chk("t3_wdata_held", mem_wdata, 32'hDEADBEEF);
        mem_data_ok = 1; #1;
        chk("t3_data_dok", oks, 4'b0001);
        step(); mem_data_ok = 0; data_size = SZ_WORD; data_wstrb = 4'hf;

        // second simultaneous pair, last grant went to data
        first_inst = RR;
        step(); inst_req = 1; inst_addr = 32'hBFC00010;
        data_req = 1; data_addr = 32'h80003000; data_size = SZ_BYTE;
        step(); #1;
        chk("t4_first_addr", mem_addr, first_inst ? 32'hBFC00010 : 32'h80003000);
        mem_addr_ok = 1; mem_data_ok = 1; #1;
        chk("t4_first_oks", oks, first_inst ? 4'b1100 : 4'b0011);
        if (first_inst) inst_req = 0; else data_req = 0;
        step(); mem_addr_ok = 0; mem_data_ok = 0; #1;
        chk("t4_gap", mem_req, 0);
        step(); #1;
        chk("t4_second_addr", mem_addr, first_inst ? 32'h80003000 : 32'hBFC00010);
        chk("t4_second_size", mem_size, first_inst ? SZ_BYTE : SZ_WORD);
        mem_addr_ok = 1; mem_data_ok = 1; #1;
        chk("t4_second_oks", oks, first_inst ? 4'b0011 : 4'b1100);
        step(); inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; data_size = SZ_WORD;

        // reset while in DATA
        step(); inst_req = 1; inst_addr = 32'hBFC00020;
        step(); mem_addr_ok = 1; #1;
        chk("t5_aok", oks, 4'b1000);
        step(); inst_req = 0; mem_addr_ok = 0; #1;
        chk("t5_in_data", mem_req, 0);
        resetn = 0; mem_data_ok = 1; #1;
        chk("t5_rst_oks", oks, 4'b0000);
        chk("t5_rst_addr", mem_addr, 0);
        chk("t5_rst_req", mem_req, 0);
        step(); resetn = 1; #1;
        chk("t5_late_dok", oks, 4'b0000);
        step(); mem_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC00030; #1;
        chk("t5_late_gone", oks, 4'b0000);
        step(); #1;
        chk("t5_next_req", mem_req, 1);
        chk("t5_next_addr", mem_addr, 32'hBFC00030);
        mem_addr_ok = 1; mem_data_ok = 1; #1;
        chk("t5_next_oks", oks, 4'b1100);
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;

        // 100 back-to-back fetches with zero-wait memory
        step(); inst_req = 1; inst_addr = 32'h00001000; mem_addr_ok = 1; mem_data_ok = 1;
        n_tx = 0; n_low = 0; cyc = 0; gap_err = 0; pulse_err = 0; addr_err = 0; seen = 0;
        while (n_tx < 100 && cyc < 1000) begin
            step(); mem_rdata = 32'hA0000000 + n_tx; #1;
            cyc++;
            if (mem_req) begin
                if (seen && n_low != 1) gap_err++;
                if (mem_addr !== 32'h00001000 + 4 * n_tx) addr_err++;
                seen = 1; n_low = 0;
            end else begin
                n_low++;
            end
            if (inst_addr_ok !== mem_req || inst_data_ok !== mem_req || data_addr_ok || data_data_ok)
                pulse_err++;
            if (inst_data_ok) begin
                n_tx++;
                inst_addr = 32'h00001000 + 4 * n_tx;
            end
        end
        step(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0; #1;
        chk("bb_count", n_tx, 100);
        chk("bb_gap_err", gap_err, 0);
        chk("bb_pulse_err", pulse_err, 0);
        chk("bb_addr_err", addr_err, 0);
        chk("bb_end_idle", mem_req, 0);
        step(); #1;
        chk("bb_no_extra", mem_req, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
